// File: rtl/ec_flags_capture_pio.sv
// ---------------------------------------------------------------------------
// ec_flags_capture_pio
//
// Avalon-MM input port for the error-correction status flags. Each flag line
// is synchronised, selected edges are latched into write-1-to-clear capture
// bits, capture events are counted, and a maskable level interrupt is raised.
// Register 0 reads the same synchronised level as the plain EC-flag PIO.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   address     register word address (0 DATA, 1 MASK, 2 EDGE, 3 COUNT)
//   chipselect  slave select, qualifies write
//   write_n     active-low write strobe
//   writedata   write data
//   in_port     asynchronous flag inputs
//   readdata    registered read data (one cycle after address)
//   irq         registered level interrupt
// ---------------------------------------------------------------------------
module ec_flags_capture_pio #(
    parameter int WIDTH       = 3,   // 1..32
    parameter int SYNC_STAGES = 2,   // 2..4
    parameter int EDGE_MODE   = 0,   // 0 rising, 1 falling, 2 any
    parameter int CNT_WIDTH   = 16   // 1..32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    typedef enum logic [1:0] {
        REG_DATA  = 2'd0,
        REG_MASK  = 2'd1,
        REG_EDGE  = 2'd2,
        REG_COUNT = 2'd3
    } reg_addr_e;

    // The arm counter must cover sync chain fill plus one cycle for prev.
    localparam int                ARM_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0]  ARM_MAX = ARM_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]     sync_d [SYNC_STAGES];
    logic [WIDTH-1:0]     prev_q,    prev_d;
    logic [WIDTH-1:0]     capture_q, capture_d;
    logic [WIDTH-1:0]     mask_q,    mask_d;
    logic [CNT_WIDTH-1:0] count_q,   count_d;
    logic [ARM_W-1:0]     arm_q,     arm_d;
    logic [31:0]          readdata_q, readdata_d;
    logic                 irq_q,     irq_d;

    logic [WIDTH-1:0]     level;
    logic [WIDTH-1:0]     rise;
    logic [WIDTH-1:0]     fall;
    logic [WIDTH-1:0]     ev;
    logic [WIDTH-1:0]     w1c_mask;
    logic [CNT_WIDTH-1:0] count_base;
    logic                 armed;
    logic                 wr_en;
    logic                 wr_unused;

    // Upper writedata bits are only meaningful when WIDTH is 32.
    assign wr_unused = &{1'b0, writedata};

    // NOTE: every combinational output gets a default at the top of the block
    // so no path through the if/case logic can leave it unassigned (latch).
    always_comb begin
        sync_d[0] = in_port;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end

        level  = sync_q[SYNC_STAGES-1];
        prev_d = level;

        armed = (arm_q == ARM_MAX);
        arm_d = armed ? arm_q : arm_q + 1'b1;

        rise = level & ~prev_q;
        fall = ~level & prev_q;
        case (EDGE_MODE)
            0:       ev = rise;
            1:       ev = fall;
            default: ev = rise | fall;
        endcase
        // Until the chain and prev both hold post-reset samples, any
        // difference between them is an artefact of the reset values.
        if (!armed) begin
            ev = '0;
        end

        wr_en = chipselect & ~write_n;

        w1c_mask = '0;
        if (wr_en && address == REG_EDGE) begin
            w1c_mask = writedata[WIDTH-1:0];
        end
        // New edges are ORed in after the clear, so set wins on a collision.
        capture_d = (capture_q & ~w1c_mask) | ev;

        mask_d = mask_q;
        if (wr_en && address == REG_MASK) begin
            mask_d = writedata[WIDTH-1:0];
        end

        // A clear write and an event in the same cycle leave the count at 1.
        count_base = (wr_en && address == REG_COUNT) ? '0 : count_q;
        count_d    = count_base;
        if (|ev && count_base != '1) begin
            count_d = count_base + 1'b1;
        end

        irq_d = |(capture_q & mask_q);

        readdata_d = '0;
        case (reg_addr_e'(address))
            REG_DATA:  readdata_d[WIDTH-1:0]     = level;
            REG_MASK:  readdata_d[WIDTH-1:0]     = mask_q;
            REG_EDGE:  readdata_d[WIDTH-1:0]     = capture_q;
            REG_COUNT: readdata_d[CNT_WIDTH-1:0] = count_q;
            default:   readdata_d                = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the synchroniser array is a set of flops, not a RAM, so it
            // is reset element by element like any other state.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q     <= '0;
            capture_q  <= '0;
            mask_q     <= '0;
            count_q    <= '0;
            arm_q      <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            capture_q  <= capture_d;
            mask_q     <= mask_d;
            count_q    <= count_d;
            arm_q      <= arm_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
